// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the parallel-in, serial-out transmitter.
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  // Gap counter width; covers GAP values 0..15.
  localparam int unsigned GapCntWidth = 4;

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial-side signals of the serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  // Upstream / word source side.
  modport master (
    output load_valid, load_data,
    input  load_ready, sout, sout_valid, busy, done
  );

  // Serializer side.
  modport slave (
    input  load_valid, load_data,
    output load_ready, sout, sout_valid, busy, done
  );

endinterface

// File: rtl/piso_shifter.sv
// Loadable WIDTH-bit shift register; head is the bit currently on the line.
module piso_shifter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift_en,
  input  logic             msb_first,
  output logic             head
);

  logic [WIDTH-1:0] q;

  // Parallel load wins over shift; zeros fill in behind the departing bits.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift_en) begin
      q <= msb_first ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
    end
  end

  assign head = msb_first ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with a programmable inter-word idle gap.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 2
) (
  input logic               clock,
  input logic               clear,
  piso_serializer_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
  localparam logic [GapCntWidth-1:0] LastGap = GapCntWidth'((GAP > 0) ? GAP - 1 : 0);

  state_e                 state_q;
  logic [CntW-1:0]        bit_cnt_q;
  logic [GapCntWidth-1:0] gap_cnt_q;
  logic                   ready_q;
  logic                   valid_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   accept;
  logic                   head;

  assign accept = (state_q == StIdle) && bus.load_valid && ready_q;

  // Frame sequencing; all handshake/status outputs are registered here.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StShift;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StShift: begin
          if (bit_cnt_q == LastBit) begin
            bit_cnt_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b1;
            if (GAP == 0) begin
              state_q <= StIdle;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StGap;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        StGap: begin
          if (gap_cnt_q == LastGap) begin
            gap_cnt_q <= '0;
            state_q   <= StIdle;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + GapCntWidth'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  piso_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clock     (clock),
    .clear     (clear),
    .load      (accept),
    .din       (bus.load_data),
    .shift_en  (state_q == StShift),
    .msb_first (MSB_FIRST),
    .head      (head)
  );

  // The line is forced low outside data cycles (and at once on clear).
  assign bus.sout       = valid_q & head;
  assign bus.sout_valid = valid_q;
  assign bus.load_ready = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations checked every cycle against a
// cycles-since-accept reference model, plus directed table vectors and corner cases.
module tb_piso_serializer;

  localparam int W    = 4;
  localparam int NDut = 3;
  localparam bit MSBV [NDut] = '{1'b1, 1'b0, 1'b1};
  localparam int GAPV [NDut] = '{2, 2, 0};

  logic clock = 1'b0;
  logic clear = 1'b0;

  logic [NDut-1:0] lv;
  logic [W-1:0]    ld [NDut];
  logic [NDut-1:0] rdy, sv, so, bsy, dn;

  // Reference model: mt = cycles since acceptance (0 = idle).
  int           mt    [NDut];
  logic [W-1:0] mword [NDut];
  logic         mdone [NDut];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  for (genvar i = 0; i < NDut; i++) begin : g
    piso_serializer_if #(.WIDTH(W)) bus ();
    assign bus.load_valid = lv[i];
    assign bus.load_data  = ld[i];
    assign rdy[i] = bus.load_ready;
    assign sv[i]  = bus.sout_valid;
    assign so[i]  = bus.sout;
    assign bsy[i] = bus.busy;
    assign dn[i]  = bus.done;
    piso_serializer #(
      .WIDTH     (W),
      .MSB_FIRST (MSBV[i]),
      .GAP       (GAPV[i])
    ) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
    );
  end

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int k = 0; k < NDut; k++) begin
        mt[k]    <= 0;
        mdone[k] <= 1'b0;
        mword[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NDut; k++) begin
        mdone[k] <= (mt[k] == W);
        if (mt[k] == 0) begin
          if (lv[k]) begin
            mt[k]    <= 1;
            mword[k] <= ld[k];
          end
        end else if (mt[k] == W + GAPV[k]) begin
          mt[k] <= 0;
        end else begin
          mt[k] <= mt[k] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h, want %0h", name, k, $time, act, exp);
    end
  endtask

  // Compares {ready, valid, sout, busy, done} of every DUT against the model.
  task automatic check_all();
    for (int k = 0; k < NDut; k++) begin
      logic [4:0] act;
      logic [4:0] exp;
      int tt;
      int idx;
      tt = mt[k];
      exp = '0;
      exp[4] = (tt == 0);
      exp[3] = (tt >= 1) && (tt <= W);
      if (exp[3]) begin
        idx = MSBV[k] ? W - tt : tt - 1;
        exp[2] = mword[k][idx];
      end
      exp[1] = (tt > 0);
      exp[0] = mdone[k];
      act = {rdy[k], sv[k], so[k], bsy[k], dn[k]};
      check("model", k, 32'(act), 32'(exp));
    end
  endtask

  task automatic tick();
    @(negedge clock);
    check_all();
  endtask

  // Called at a falling edge; returns at the falling edge of the done cycle.
  task automatic send(input int k, input logic [W-1:0] data, output logic [W-1:0] got,
                      output logic got_done);
    int waited;
    waited = 0;
    while (!rdy[k] && waited < 50) begin
      tick();
      waited++;
    end
    check("ready_wait", k, 32'(rdy[k]), 32'(1));
    lv[k] = 1'b1;
    ld[k] = data;
    tick();
    lv[k] = 1'b0;
    for (int b = 0; b < W; b++) begin
      got[W-1-b] = so[k];
      check("sout_valid", k, 32'(sv[k]), 32'(1));
      ld[k] = W'($urandom);  // changes mid-frame must not matter
      tick();
    end
    got_done = dn[k];
  endtask

  typedef struct {
    int           dut;
    logic [W-1:0] data;
    logic [W-1:0] bits;  // expected line bits, leftmost sent first
  } vec_t;

  initial begin
    vec_t         vecs [7];
    logic [W-1:0] got;
    logic         gd;
    logic [8:0]   s_so, s_sv, s_rdy;

    vecs[0] = '{0, 4'b1011, 4'b1011};
    vecs[1] = '{1, 4'b1000, 4'b0001};
    vecs[2] = '{1, 4'b0110, 4'b0110};
    vecs[3] = '{1, 4'b1101, 4'b1011};
    vecs[4] = '{2, 4'b1100, 4'b1100};
    vecs[5] = '{0, 4'b0001, 4'b0001};
    vecs[6] = '{2, 4'b0111, 4'b0111};

    lv = '0;
    for (int k = 0; k < NDut; k++) ld[k] = '0;

    // Reset held for three cycles.
    clear = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < NDut; k++)
      check("reset", k, 32'({rdy[k], sv[k], so[k], bsy[k], dn[k]}), 32'(5'b10000));
    clear = 1'b1;
    tick();

    // Table-driven single words with data toggled during shift.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].dut, vecs[i].data, got, gd);
      check("bits", vecs[i].dut, 32'(got), 32'(vecs[i].bits));
      check("done", vecs[i].dut, 32'(gd), 32'(1));
    end
    repeat (4) tick();

    // Back-to-back with GAP=0 and load_valid held high.
    lv[2] = 1'b1;
    ld[2] = 4'hA;
    tick();
    ld[2] = 4'h5;
    for (int c = 0; c < 9; c++) begin
      s_so[8-c]  = so[2];
      s_sv[8-c]  = sv[2];
      s_rdy[8-c] = rdy[2];
      tick();
    end
    lv[2] = 1'b0;
    check("b2b_sout", 2, 32'(s_so), 32'(9'b1010_0_0101));
    check("b2b_valid", 2, 32'(s_sv), 32'(9'b1111_0_1111));
    check("b2b_ready", 2, 32'(s_rdy), 32'(9'b0000_1_0000));
    repeat (3) tick();

    // Mid-frame asynchronous reset after two bits.
    lv[0] = 1'b1;
    ld[0] = 4'b1111;
    tick();
    lv[0] = 1'b0;
    tick();
    @(posedge clock);
    #2;
    check("pre_clear_valid", 0, 32'(sv[0]), 32'(1));
    clear = 1'b0;
    #1;
    check("async_clear", 0, 32'({rdy[0], sv[0], so[0], bsy[0], dn[0]}), 32'(5'b10000));
    tick();
    clear = 1'b1;
    tick();
    check("no_done_after_clear", 0, 32'(dn[0]), 32'(0));
    send(0, 4'b0110, got, gd);
    check("post_clear_bits", 0, 32'(got), 32'(4'b0110));
    repeat (4) tick();

    // Release of clear coincident with load_valid: accept on the first edge.
    clear = 1'b0;
    lv[1] = 1'b1;
    ld[1] = 4'b1001;
    tick();
    clear = 1'b1;
    tick();
    lv[1] = 1'b0;
    check("release_accept_valid", 1, 32'(sv[1]), 32'(1));
    check("release_accept_bit", 1, 32'(so[1]), 32'(1));
    repeat (8) tick();

    // Random traffic with occasional resets; the model checks every cycle.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NDut; k++) begin
        lv[k] = ($urandom_range(0, 3) != 0);
        ld[k] = W'($urandom);
      end
      clear = ($urandom_range(0, 59) != 0);
      tick();
    end
    clear = 1'b1;
    lv = '0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. It is the feeding end of the 4-bit serial shift-register chain.
- Accepts a WIDTH-bit word through a valid/ready handshake and drives it one bit per clock onto a serial line. That line connects directly to the chain's serial input A.
- Inserts a programmable idle gap between words so the downstream receiver can frame them.

Parameters:
- WIDTH, 4, word length in bits, minimum 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- GAP, 2, idle cycles inserted after each word, range 0..15.

Ports:
- clock  input  1  single system clock, rising-edge.
- clear  input  1  asynchronous, active-low reset.
- load_valid  input  1  upstream word available.
- load_data  input  WIDTH  word to transmit; sampled only on handshake.
- load_ready  output  1  serializer can accept a word this cycle.
- sout  output  1  serial data, drives the shift register's A input.
- sout_valid  output  1  sout carries a data bit this cycle.
- busy  output  1  frame or gap in progress.
- done  output  1  one-cycle pulse after the last bit of a word.

Behaviour:
- Interface: one clock (clock); reset (clear) is asynchronous and active-low. clear=0 forces all state immediately, with no clock edge required.
- Reset values: load_ready=1, sout=0, sout_valid=0, busy=0, done=0, FSM=IDLE, bit counter=0, gap counter=0, shift register=0.
- FSM states and transitions:
  - IDLE -> SHIFT on load_valid && load_ready.
  - SHIFT -> GAP after the WIDTH-th bit when GAP>0.
  - SHIFT -> IDLE after the WIDTH-th bit when GAP=0.
  - GAP -> IDLE after GAP cycles.
- load_ready = (state==IDLE). The handshake completes on a rising edge with load_valid=1 and load_ready=1. Words are never accepted in SHIFT or GAP.
- Latency:
  - First bit appears on sout in the cycle immediately after the accepting edge (registered output).
  - Bits are on consecutive cycles; the last bit is in cycle WIDTH after acceptance.
- Bit order:
  - MSB_FIRST=1: load_data[WIDTH-1] is sent first, down to [0].
  - MSB_FIRST=0: the reverse.
- sout_valid=1 exactly during the WIDTH data cycles. Outside them, sout is held at 0.
- done = 1 for exactly one cycle: the first cycle after the last data bit, which is the first GAP cycle or the first IDLE cycle.
- busy = (state != IDLE).
- Throughput: one word per WIDTH+GAP+1 cycles. With load_valid held high, the next accept occurs on the first IDLE edge.
- Counter width: $clog2(WIDTH) for the bit counter, 4 bits for the gap counter. Both wrap to 0 on state exit, never by overflow.
- load_data changing while in SHIFT has no effect; the word is captured at acceptance.
- clear asserted mid-frame: the frame is discarded, no done pulse is produced, and sout=0 immediately. After release, the block is in IDLE with load_ready=1.
- clear released coincident with load_valid=1: the accept happens on the first rising edge after release.

Decomposition:
- Shared package: serializer state enum (IDLE, SHIFT, GAP) and the GAP counter width constant.
- One natural sub-module: piso_shifter. It is a WIDTH-bit loadable shift register with parallel load, shift-enable and direction select, reset by clear.
- The FSM and counters stay in the top module.

Test Plan:
- Reset: hold clear=0 for 3 cycles -> sout=0, sout_valid=0, busy=0, load_ready=1. Assert clear mid-cycle -> outputs drop without waiting for a clock edge.
- Single word: WIDTH=4, MSB_FIRST=1, GAP=2, load 4'b1011 -> sout=1,0,1,1 on cycles 1-4 with sout_valid=1; done on cycle 5; load_ready back to 1 on cycle 7.
- LSB first: MSB_FIRST=0, load 4'b1000 -> sout=0,0,0,1. Downstream shiftreg_4bit output E shows the same pattern delayed by 4 cycles.
- Back-to-back: GAP=0, load_valid held high with words 4'hA then 4'h5 -> serial stream 1,0,1,0,(idle),0,1,0,1, with exactly one idle cycle between words. load_ready=0 throughout both SHIFT phases.
- Mid-frame reset: load 4'b1111, pull clear low after bit 2 -> sout=0 at once and no done pulse. After release, load 4'b0110 -> clean 0,1,1,0.
- Backpressure ignored: toggle load_data during SHIFT -> the transmitted word equals the value captured at acceptance.
